reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Reset sequencer between the board-level reset generator and the system. Merges the power-on/button reset with run-time restart requests (watchdog, stack-overflow trap, software) and drives staged reset outputs: peripherals released first, CPU a fixed number of cycles later. Records the cause of the last reset and a restart count in a CPU-readable status register, so the restarted Oberon system can tell a cold start from a recovery.

## Interface
Parameters:
- HOLD_CYCLES, 16: cycles both resets stay asserted; legal range 2..65535.
- STAGE_GAP, 8: cycles between peripheral release and CPU release; legal range 1..65535.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous and active-low; deassertion is already synchronous to clk upstream.
- wd_trig  in  1  watchdog timeout, one-cycle pulse.
- kill_trig  in  1  trap/stack-overflow restart request, one-cycle pulse.
- sw_wr  in  1  status-register write strobe.
- sw_wdata  in  8  write data: bit0 = request restart, bit1 = clear cause and count.
- sw_rdata  out  16  status: [3:0] cause one-hot {sw, kill, wd, por}, [7:4] zero, [15:8] restart count.
- rst_periph_n  out  1  peripheral reset, active-low.
- rst_cpu_n  out  1  CPU reset, active-low.
- busy  out  1  high whenever state is not RUN.

## Operation
- States: HOLD, STAGE, RUN. 16-bit counter cnt. 4-bit cause register. 8-bit restart count rcnt.
- Reset (rst_n low, asynchronous): state HOLD, cnt 0, rst_periph_n 0, rst_cpu_n 0, busy 1, cause 4'b0001 (por), rcnt 0.
- HOLD: cnt increments each cycle. When cnt == HOLD_CYCLES-1: rst_periph_n <= 1, cnt <= 0, state <= STAGE.
- STAGE: cnt increments each cycle. When cnt == STAGE_GAP-1: rst_cpu_n <= 1, busy <= 0, state <= RUN.
- RUN: a trigger is wd_trig, kill_trig, or (sw_wr & sw_wdata[0]).
  - Any trigger: rst_periph_n <= 0, rst_cpu_n <= 0, busy <= 1, cnt <= 0, state <= HOLD.
  - Cause is overwritten one-hot with the highest-priority active source: wd > kill > sw.
  - rcnt increments and saturates at 255.
- Clear: sw_wr & sw_wdata[1] in RUN with no trigger that cycle sets cause <= 0 and rcnt <= 0. If a trigger occurs in the same cycle, the trigger wins and the clear is dropped.
- Triggers and writes outside RUN (HOLD, STAGE) are ignored: no restart of the sequence, no change to cause or rcnt.
- sw_rdata is combinational from the registers and valid in every state.

## Timing
- All outputs are registered. Only rst_n acts asynchronously.
- Trigger sampled at edge N in RUN: both resets are low after edge N.
- rst_periph_n is low for exactly HOLD_CYCLES cycles.
- rst_cpu_n is low for exactly HOLD_CYCLES+STAGE_GAP cycles.
- After rst_n deasserts: rst_periph_n rises at the HOLD_CYCLES-th rising edge, and rst_cpu_n rises STAGE_GAP edges later.
- busy falls in the same cycle that rst_cpu_n rises.
- Trigger-to-reset latency is 1 edge. Same-cycle cause/rcnt update.
- rst_n asserted mid-sequence: immediate return to reset values; cause becomes por and rcnt clears.

## Test plan
- Power-on, defaults: release rst_n at edge 0 -> rst_periph_n rises at edge 16, rst_cpu_n and busy change at edge 24, sw_rdata = 16'h0001.
- Watchdog in RUN: wd_trig pulse -> both resets low next edge, periph low 16 cycles, CPU low 24 cycles, sw_rdata = 16'h0102.
- Simultaneous sources: wd_trig, kill_trig and sw request in one cycle -> cause 4'b0010 (wd only), rcnt +1.
- Ignored during sequence: kill_trig during HOLD and sw write 8'h01 during STAGE -> release timing unchanged, cause and rcnt unchanged.
- Clear vs trigger: sw_wdata 8'h02 alone in RUN -> sw_rdata = 16'h0000. sw_wdata 8'h03 -> restart with cause 4'b1000, rcnt 1.
- Saturation and async reset: 260 sw restarts -> rcnt = 255. Pulse rst_n low during STAGE -> outputs low immediately, sw_rdata = 16'h0001.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: merges board reset with run-time restart requests,
// releases peripherals before the CPU and records cause and restart count.
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wd_trig,
    input  logic        kill_trig,
    input  logic        sw_wr,
    input  logic [7:0]  sw_wdata,
    output logic [15:0] sw_rdata,
    output logic        rst_periph_n,
    output logic        rst_cpu_n,
    output logic        busy
);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        STAGE = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] STAGE_LAST = 16'(STAGE_GAP - 1);

    // Fixed priority wd > kill > sw; cause bits are {sw, kill, wd, por}.
    function automatic logic [3:0] pick_cause(input logic wd, input logic kill, input logic sw);
        logic [3:0] c;
        if (wd) begin
            c = 4'b0010;
        end else if (kill) begin
            c = 4'b0100;
        end else if (sw) begin
            c = 4'b1000;
        end else begin
            c = 4'b0000;
        end
        return c;
    endfunction

    state_t      state_r;
    logic [15:0] cnt_r;
    logic [3:0]  cause_r;
    logic [7:0]  rcnt_r;
    logic        periph_n_r;
    logic        cpu_n_r;
    logic        busy_r;

    logic        sw_req_s;
    logic        sw_clr_s;
    logic        trig_s;
    logic [3:0]  cause_next_s;
    logic        unused_s;

    // Decode restart and clear requests for the current cycle.
    always_comb begin
        sw_req_s     = sw_wr & sw_wdata[0];
        sw_clr_s     = sw_wr & sw_wdata[1];
        trig_s       = wd_trig | kill_trig | sw_req_s;
        cause_next_s = pick_cause(wd_trig, kill_trig, sw_req_s);
        unused_s     = ^sw_wdata[7:2];
    end

    // Sequencer FSM with registered reset outputs and status bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= HOLD;
            cnt_r      <= 16'd0;
            cause_r    <= 4'b0001;
            rcnt_r     <= 8'd0;
            periph_n_r <= 1'b0;
            cpu_n_r    <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            case (state_r)
                HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        periph_n_r <= 1'b1;
                        cnt_r      <= 16'd0;
                        state_r    <= STAGE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                STAGE: begin
                    if (cnt_r == STAGE_LAST) begin
                        cpu_n_r <= 1'b1;
                        busy_r  <= 1'b0;
                        cnt_r   <= 16'd0;
                        state_r <= RUN;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                RUN: begin
                    // A restart request always beats a same-cycle clear.
                    if (trig_s) begin
                        periph_n_r <= 1'b0;
                        cpu_n_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        cnt_r      <= 16'd0;
                        state_r    <= HOLD;
                        cause_r    <= cause_next_s;
                        if (rcnt_r != 8'hFF) begin
                            rcnt_r <= rcnt_r + 8'd1;
                        end else begin
                            rcnt_r <= rcnt_r;
                        end
                    end else if (sw_clr_s) begin
                        cause_r <= 4'b0000;
                        rcnt_r  <= 8'd0;
                    end else begin
                        cnt_r <= 16'd0;
                    end
                end
                default: begin
                    state_r    <= HOLD;
                    cnt_r      <= 16'd0;
                    periph_n_r <= 1'b0;
                    cpu_n_r    <= 1'b0;
                    busy_r     <= 1'b1;
                end
            endcase
        end
    end

    assign sw_rdata     = {rcnt_r, 4'b0000, cause_r};
    assign rst_periph_n = periph_n_r;
    assign rst_cpu_n    = cpu_n_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer with default parameters.
module tb_reset_sequencer;

    logic        clk;
    logic        rst_n;
    logic        wd_trig;
    logic        kill_trig;
    logic        sw_wr;
    logic [7:0]  sw_wdata;
    logic [15:0] sw_rdata;
    logic        rst_periph_n;
    logic        rst_cpu_n;
    logic        busy;

    int n_cmp;
    int n_bad;
    int n_timeout;

    reset_sequencer #(.HOLD_CYCLES(16), .STAGE_GAP(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wd_trig      (wd_trig),
        .kill_trig    (kill_trig),
        .sw_wr        (sw_wr),
        .sw_wdata     (sw_wdata),
        .sw_rdata     (sw_rdata),
        .rst_periph_n (rst_periph_n),
        .rst_cpu_n    (rst_cpu_n),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wd_trig   = 1'b0;
        kill_trig = 1'b0;
        sw_wr     = 1'b0;
        sw_wdata  = 8'h00;
    endtask

    // Count edges until each reset rises, optionally injecting ignored requests.
    task automatic measure(input string tag, input int kill_at, input int sw_at);
        int  k;
        int  pk;
        bit  bad;
        k   = 0;
        pk  = -1;
        bad = 1'b0;
        while (rst_cpu_n !== 1'b1 && k < 200) begin
            kill_trig = (k == kill_at);
            sw_wr     = (k == sw_at);
            sw_wdata  = (k == sw_at) ? 8'h01 : 8'h00;
            step();
            k++;
            if (pk < 0 && rst_periph_n === 1'b1) pk = k;
            if (pk >= 0 && rst_periph_n !== 1'b1) bad = 1'b1;
            if (rst_cpu_n !== 1'b1 && busy !== 1'b1) bad = 1'b1;
        end
        idle_inputs();
        check_val({tag, "_periph_edge"}, pk, 32'd16);
        check_val({tag, "_cpu_edge"}, k, 32'd24);
        check_val({tag, "_busy_end"}, busy, 32'd0);
        check_val({tag, "_glitch"}, bad, 32'd0);
    endtask

    // Apply one request cycle in RUN and confirm both resets drop on that edge.
    task automatic trigger(input string tag, input logic wd, input logic kill, input logic [7:0] wdata);
        wd_trig   = wd;
        kill_trig = kill;
        sw_wr     = (wdata != 8'h00);
        sw_wdata  = wdata;
        step();
        idle_inputs();
        check_val({tag, "_low"}, {rst_periph_n, rst_cpu_n, busy}, 32'b001);
    endtask

    task automatic quick_restart();
        int n;
        sw_wr    = 1'b1;
        sw_wdata = 8'h01;
        step();
        idle_inputs();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) n_timeout++;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        n_timeout = 0;
        rst_n     = 1'b0;
        idle_inputs();
        repeat (3) step();
        check_val("rst_state", {rst_periph_n, rst_cpu_n, busy}, 32'b001);
        check_val("rst_rdata", sw_rdata, 32'h0001);

        rst_n = 1'b1;
        measure("por", -1, -1);
        check_val("por_rdata", sw_rdata, 32'h0001);

        trigger("wd", 1'b1, 1'b0, 8'h00);
        check_val("wd_rdata_now", sw_rdata, 32'h0102);
        measure("wd", -1, -1);
        check_val("wd_rdata", sw_rdata, 32'h0102);

        trigger("all", 1'b1, 1'b1, 8'h01);
        measure("all", -1, -1);
        check_val("all_rdata", sw_rdata, 32'h0202);

        trigger("kill", 1'b0, 1'b1, 8'h00);
        measure("ign", 3, 18);
        check_val("ign_rdata", sw_rdata, 32'h0304);

        sw_wr    = 1'b1;
        sw_wdata = 8'h02;
        step();
        idle_inputs();
        check_val("clr_rdata", sw_rdata, 32'h0000);
        check_val("clr_state", {rst_periph_n, rst_cpu_n, busy}, 32'b110);

        trigger("clrtrig", 1'b0, 1'b0, 8'h03);
        check_val("clrtrig_rdata_now", sw_rdata, 32'h0108);
        measure("clrtrig", -1, -1);
        check_val("clrtrig_rdata", sw_rdata, 32'h0108);

        for (int i = 0; i < 253; i++) quick_restart();
        check_val("sat_254", sw_rdata, 32'hFE08);
        for (int i = 0; i < 7; i++) quick_restart();
        check_val("sat_255", sw_rdata, 32'hFF08);
        check_val("sat_timeouts", n_timeout, 32'd0);

        trigger("wd2", 1'b1, 1'b0, 8'h00);
        repeat (18) step();
        check_val("stage_pre", {rst_periph_n, rst_cpu_n, busy}, 32'b101);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_state", {rst_periph_n, rst_cpu_n, busy}, 32'b001);
        check_val("async_rdata", sw_rdata, 32'h0001);
        step();
        rst_n = 1'b1;
        measure("por2", -1, -1);
        check_val("por2_rdata", sw_rdata, 32'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
